// File: rtl/hazard_pkg.sv
// hazard_pkg: bypass select codes, Tuse/Tnew encodings, stage record and match helpers for hazard_sched
package hazard_pkg;
    typedef enum logic [2:0] {
        FWD_NONE  = 3'd0,
        FWD_E_PC8 = 3'd1,
        FWD_M_RES = 3'd2,
        FWD_W_WD  = 3'd3
    } fwd_sel_e;

    localparam logic [1:0] TUSE_NONE = 2'd3;
    localparam logic [1:0] TNEW_PC8  = 2'd0;
    localparam logic [1:0] TNEW_ALU  = 2'd1;
    localparam logic [1:0] TNEW_LOAD = 2'd2;

    typedef struct packed {
        logic       valid;
        logic [4:0] wreg;
        logic [1:0] tnew;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       md_start;
        logic       md_div;
    } stage_t;

    localparam stage_t STAGE_BUBBLE = '0;

    function automatic logic hit(input stage_t s, input logic [4:0] src);
        return s.valid && s.wreg != 5'd0 && s.wreg == src;
    endfunction

    function automatic stage_t advance(input stage_t s);
        stage_t r;
        r = s;
        r.tnew = (s.tnew == TNEW_PC8) ? s.tnew : s.tnew - 2'd1;
        return r;
    endfunction

    // Youngest matching producer decides; an older stage is never consulted past a match.
    function automatic logic src_stall(input stage_t e, input stage_t m, input stage_t w,
                                       input logic [4:0] src, input logic [1:0] tuse);
        if (tuse == TUSE_NONE || src == 5'd0) return 1'b0;
        return hit(e, src) ? (e.tnew > tuse) :
               hit(m, src) ? (m.tnew > tuse) :
               hit(w, src) ? (w.tnew > tuse) : 1'b0;
    endfunction

    function automatic fwd_sel_e fwd_sel(input stage_t e, input stage_t m, input stage_t w,
                                         input logic [4:0] src);
        return hit(e, src) ? ((e.tnew == TNEW_PC8) ? FWD_E_PC8 : FWD_NONE) :
               hit(m, src) ? ((m.tnew == TNEW_PC8) ? FWD_M_RES : FWD_NONE) :
               hit(w, src) ? FWD_W_WD : FWD_NONE;
    endfunction
endpackage

// File: rtl/hazard_sched_if.sv
// hazard_sched_if: D-stage hazard info in, stall/bypass selects/md_busy out
//   master: pipeline side (drives d_*), slave: hazard_sched
interface hazard_sched_if;
    logic       d_valid;
    logic [4:0] d_rs;
    logic [4:0] d_rt;
    logic [1:0] d_tuse_rs;
    logic [1:0] d_tuse_rt;
    logic [4:0] d_wreg;
    logic [1:0] d_tnew;
    logic       d_md_start;
    logic       d_md_div;
    logic       d_md_use;
    logic       stall;
    logic [2:0] fwd_d_rs;
    logic [2:0] fwd_d_rt;
    logic [2:0] fwd_e_rs;
    logic [2:0] fwd_e_rt;
    logic [2:0] fwd_m_rt;
    logic       md_busy;

    modport master (
        output d_valid, d_rs, d_rt, d_tuse_rs, d_tuse_rt, d_wreg, d_tnew, d_md_start, d_md_div, d_md_use,
        input  stall, fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt, fwd_m_rt, md_busy
    );
    modport slave (
        input  d_valid, d_rs, d_rt, d_tuse_rs, d_tuse_rt, d_wreg, d_tnew, d_md_start, d_md_div, d_md_use,
        output stall, fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt, fwd_m_rt, md_busy
    );
endinterface

// File: rtl/hazard_sched_md_busy_timer.sv
// md_busy_timer: mult/div busy countdown
//   clk, rst_n (async, active-low); load: E holds mult/div; div: 1 = div family; md_busy: counter != 0
module md_busy_timer #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic div,
    output logic md_busy
);
    localparam int W = $clog2((MULT_CYCLES > DIV_CYCLES ? MULT_CYCLES : DIV_CYCLES) + 1);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb cnt_d = load ? (div ? W'(DIV_CYCLES) : W'(MULT_CYCLES)) :
                        (cnt_q != '0) ? cnt_q - W'(1) : cnt_q;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;

    assign md_busy = cnt_q != '0;
endmodule

// File: rtl/hazard_sched.sv
// hazard_sched: 5-stage pipeline hazard scheduler (D stall, D/E/M bypass selects, mult/div interlock)
//   clk, rst_n (async, active-low); hz: hazard_sched_if.slave
//   HAZARD_STATS_EN defined: adds output stall_cnt[31:0] counting stalled cycles (wrapping)
module hazard_sched
    import hazard_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input logic           clk,
    input logic           rst_n,
    hazard_sched_if.slave hz
`ifdef HAZARD_STATS_EN
    ,
    output logic [31:0]   stall_cnt
`endif
);
    stage_t e_q, m_q, w_q, e_d, m_d, w_d;
    logic   stall, md_busy;

    always_comb begin
        stall = src_stall(e_q, m_q, w_q, hz.d_rs, hz.d_tuse_rs) |
                src_stall(e_q, m_q, w_q, hz.d_rt, hz.d_tuse_rt) |
                ((hz.d_md_use | hz.d_md_start) & (md_busy | e_q.md_start));
        e_d = stall ? STAGE_BUBBLE : '{valid: hz.d_valid, wreg: hz.d_wreg, tnew: hz.d_tnew,
                                       rs: hz.d_rs, rt: hz.d_rt,
                                       md_start: hz.d_md_start, md_div: hz.d_md_div};
        m_d = advance(e_q);
        w_d = advance(m_q);
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            e_q <= STAGE_BUBBLE;
            m_q <= STAGE_BUBBLE;
            w_q <= STAGE_BUBBLE;
        end else begin
            e_q <= e_d;
            m_q <= m_d;
            w_q <= w_d;
        end

    md_busy_timer #(.MULT_CYCLES(MULT_CYCLES), .DIV_CYCLES(DIV_CYCLES)) u_md_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (e_q.md_start),
        .div     (e_q.md_div),
        .md_busy (md_busy)
    );

    // Later stages are consulted by passing a bubble in place of the stages they cannot see.
    assign hz.stall    = stall;
    assign hz.md_busy  = md_busy;
    assign hz.fwd_d_rs = fwd_sel(e_q, m_q, w_q, hz.d_rs);
    assign hz.fwd_d_rt = fwd_sel(e_q, m_q, w_q, hz.d_rt);
    assign hz.fwd_e_rs = fwd_sel(STAGE_BUBBLE, m_q, w_q, e_q.rs);
    assign hz.fwd_e_rt = fwd_sel(STAGE_BUBBLE, m_q, w_q, e_q.rt);
    assign hz.fwd_m_rt = fwd_sel(STAGE_BUBBLE, STAGE_BUBBLE, w_q, m_q.rt);

    logic unused;
    assign unused = ^{m_q.rs, m_q.md_start, m_q.md_div, w_q.rs, w_q.rt, w_q.md_start, w_q.md_div};

`ifdef HAZARD_STATS_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb stall_cnt_d = stall_cnt_q + 32'(stall);

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) stall_cnt_q <= '0;
        else        stall_cnt_q <= stall_cnt_d;

    assign stall_cnt = stall_cnt_q;
`endif
endmodule

// File: tb/tb_hazard_sched.sv
// tb_hazard_sched: directed pipeline scenarios plus random D traffic against a behavioural model
module tb_hazard_sched;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    hazard_sched_if hz ();
`ifdef HAZARD_STATS_EN
    logic [31:0] stall_cnt;
    int          exp_cnt;
`endif

    hazard_sched dut (
        .clk   (clk),
        .rst_n (rst_n),
        .hz    (hz)
`ifdef HAZARD_STATS_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Model: in-flight instructions indexed by stage (0=E, 1=M, 2=W), plus remaining md cycles.
    int pv[3], pw[3], pt[3], prs[3], prt[3], pmd[3], pdiv[3];
    int md_left;

    function automatic void mreset();
        for (int k = 0; k < 3; k++) begin
            pv[k] = 0; pw[k] = 0; pt[k] = 0; prs[k] = 0; prt[k] = 0; pmd[k] = 0; pdiv[k] = 0;
        end
        md_left = 0;
`ifdef HAZARD_STATS_EN
        exp_cnt = 0;
`endif
    endfunction

    function automatic int producer(int src, int from);
        for (int k = from; k < 3; k++)
            if (pv[k] != 0 && pw[k] != 0 && pw[k] == src) return k;
        return -1;
    endfunction

    function automatic int src_wait(int src, int tuse);
        int k;
        if (tuse == 3 || src == 0) return 0;
        k = producer(src, 0);
        return (k >= 0 && pt[k] > tuse) ? 1 : 0;
    endfunction

    function automatic int m_stall();
        int md_req;
        md_req = (hz.d_md_use || hz.d_md_start) ? 1 : 0;
        return (src_wait(int'(hz.d_rs), int'(hz.d_tuse_rs)) != 0 ||
                src_wait(int'(hz.d_rt), int'(hz.d_tuse_rt)) != 0 ||
                (md_req != 0 && (md_left > 0 || pmd[0] != 0))) ? 1 : 0;
    endfunction

    function automatic int m_fwd(int src, int from);
        int k;
        k = producer(src, from);
        if (k < 0) return 0;
        if (k == 2) return 3;
        return (pt[k] == 0) ? k + 1 : 0;
    endfunction

    function automatic void m_advance();
        int st;
        st = m_stall();
        if (pmd[0] != 0) md_left = (pdiv[0] != 0) ? 10 : 5;
        else if (md_left > 0) md_left--;
        for (int k = 2; k > 0; k--) begin
            pv[k] = pv[k-1]; pw[k] = pw[k-1]; prs[k] = prs[k-1]; prt[k] = prt[k-1];
            pmd[k] = pmd[k-1]; pdiv[k] = pdiv[k-1];
            pt[k] = (pt[k-1] > 0) ? pt[k-1] - 1 : 0;
        end
        if (st != 0) begin
            pv[0] = 0; pw[0] = 0; pt[0] = 0; prs[0] = 0; prt[0] = 0; pmd[0] = 0; pdiv[0] = 0;
        end else begin
            pv[0] = int'(hz.d_valid); pw[0] = int'(hz.d_wreg); pt[0] = int'(hz.d_tnew);
            prs[0] = int'(hz.d_rs); prt[0] = int'(hz.d_rt);
            pmd[0] = int'(hz.d_md_start); pdiv[0] = int'(hz.d_md_div);
        end
`ifdef HAZARD_STATS_EN
        exp_cnt += st;
`endif
    endfunction

    task automatic check_all();
        check("stall",    32'(hz.stall),    m_stall());
        check("fwd_d_rs", 32'(hz.fwd_d_rs), m_fwd(int'(hz.d_rs), 0));
        check("fwd_d_rt", 32'(hz.fwd_d_rt), m_fwd(int'(hz.d_rt), 0));
        check("fwd_e_rs", 32'(hz.fwd_e_rs), m_fwd(prs[0], 1));
        check("fwd_e_rt", 32'(hz.fwd_e_rt), m_fwd(prt[0], 1));
        check("fwd_m_rt", 32'(hz.fwd_m_rt), m_fwd(prt[1], 2));
        check("md_busy",  32'(hz.md_busy),  (md_left > 0) ? 1 : 0);
`ifdef HAZARD_STATS_EN
        check("stall_cnt", stall_cnt, exp_cnt);
`endif
    endtask

    task automatic tick();
        check_all();
        @(posedge clk);
        if (rst_n) m_advance();
        else mreset();
        @(negedge clk);
    endtask

    task automatic set_d(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [1:0] urs, input logic [1:0] urt,
                         input logic [4:0] wr, input logic [1:0] tn,
                         input logic ms, input logic md, input logic mu);
        hz.d_valid = v; hz.d_rs = rs; hz.d_rt = rt; hz.d_tuse_rs = urs; hz.d_tuse_rt = urt;
        hz.d_wreg = wr; hz.d_tnew = tn; hz.d_md_start = ms; hz.d_md_div = md; hz.d_md_use = mu;
        #1;
    endtask

    task automatic nop();
        set_d(1'b0, 5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic flush();
        repeat (3) begin
            nop();
            tick();
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        mreset();
        nop();
        #1;
        check("rst_stall", 32'(hz.stall), 0);
        check("rst_md_busy", 32'(hz.md_busy), 0);
        check("rst_fwd_e_rs", 32'(hz.fwd_e_rs), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // 1: ALU result in E, D consumes in D -> one stall, then bypass from M
        set_d(1'b1, 5'd0, 5'd0, 2'd3, 2'd3, 5'd1, 2'd1, 1'b0, 1'b0, 1'b0);
        tick();
        set_d(1'b1, 5'd1, 5'd0, 2'd0, 2'd3, 5'd4, 2'd1, 1'b0, 1'b0, 1'b0);
        check("t1_stall", 32'(hz.stall), 1);
        tick();
        check("t1_release", 32'(hz.stall), 0);
        check("t1_fwd_d_rs", 32'(hz.fwd_d_rs), 2);
        tick();
        flush();

        // 2: load in E, D needs it in E -> one stall, then W bypass into E
        set_d(1'b1, 5'd0, 5'd0, 2'd3, 2'd3, 5'd2, 2'd2, 1'b0, 1'b0, 1'b0);
        tick();
        set_d(1'b1, 5'd2, 5'd0, 2'd1, 2'd3, 5'd5, 2'd1, 1'b0, 1'b0, 1'b0);
        check("t2_stall", 32'(hz.stall), 1);
        tick();
        check("t2_release", 32'(hz.stall), 0);
        tick();
        nop();
        check("t2_fwd_e_rs", 32'(hz.fwd_e_rs), 3);
        tick();
        flush();

        // 3: jal in E, jr $31 in D -> pc+8 bypass without stall
        set_d(1'b1, 5'd0, 5'd0, 2'd3, 2'd3, 5'd31, 2'd0, 1'b0, 1'b0, 1'b0);
        tick();
        set_d(1'b1, 5'd31, 5'd0, 2'd0, 2'd3, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
        check("t3_stall", 32'(hz.stall), 0);
        check("t3_fwd_d_rs", 32'(hz.fwd_d_rs), 1);
        tick();
        flush();

        // 4: $3 written by E and M -> E wins; writes to $0 never match
        set_d(1'b1, 5'd0, 5'd0, 2'd3, 2'd3, 5'd3, 2'd0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        set_d(1'b1, 5'd3, 5'd0, 2'd0, 2'd3, 5'd0, 2'd2, 1'b0, 1'b0, 1'b0);
        check("t4_stall", 32'(hz.stall), 0);
        check("t4_fwd_youngest", 32'(hz.fwd_d_rs), 1);
        tick();
        set_d(1'b1, 5'd0, 5'd0, 2'd0, 2'd0, 5'd6, 2'd1, 1'b0, 1'b0, 1'b0);
        check("t4_r0_stall", 32'(hz.stall), 0);
        check("t4_r0_fwd_rs", 32'(hz.fwd_d_rs), 0);
        check("t4_r0_fwd_rt", 32'(hz.fwd_d_rt), 0);
        tick();
        flush();

        // 5: div then mflo -> stalls for DIV_CYCLES+1 cycles
        set_d(1'b1, 5'd8, 5'd9, 2'd1, 2'd1, 5'd0, 2'd0, 1'b1, 1'b1, 1'b0);
        tick();
        set_d(1'b1, 5'd0, 5'd0, 2'd3, 2'd3, 5'd7, 2'd1, 1'b0, 1'b0, 1'b1);
        n = 0;
        while (hz.stall && n < 30) begin
            n++;
            tick();
        end
        check("t5_stall_cycles", n, 11);
        check("t5_released", 32'(hz.stall), 0);
        check("t5_md_idle", 32'(hz.md_busy), 0);
        tick();
        flush();

        // 6: reset mid-divide with mflo stalled in D
        set_d(1'b1, 5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 2'd0, 1'b1, 1'b1, 1'b0);
        tick();
        set_d(1'b1, 5'd0, 5'd0, 2'd3, 2'd3, 5'd7, 2'd1, 1'b0, 1'b0, 1'b1);
        repeat (3) tick();
        check("t6_pre_stall", 32'(hz.stall), 1);
        rst_n = 1'b0;
        #1;
        check("t6_stall", 32'(hz.stall), 0);
        check("t6_md_busy", 32'(hz.md_busy), 0);
        check("t6_fwd_d_rs", 32'(hz.fwd_d_rs), 0);
        check("t6_fwd_m_rt", 32'(hz.fwd_m_rt), 0);
`ifdef HAZARD_STATS_EN
        check("t6_stall_cnt", stall_cnt, 0);
`endif
        mreset();
        tick();
        rst_n = 1'b1;
        #1;
        check("t6_clean_stall", 32'(hz.stall), 0);
        check("t6_clean_md_busy", 32'(hz.md_busy), 0);
        tick();
        flush();

        // Random D traffic over a small register set to provoke matches
        for (int i = 0; i < 1500; i++) begin
            set_d(1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                  5'($urandom_range(0, 3)), 2'($urandom_range(0, 2)),
                  1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 7) == 0));
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
